uart_param: RTL

Parametrised full-duplex UART. It is the successor to the fixed 8-bit UART, adding configurable data width, parity mode, stop-bit count and baud divider. RX uses mid-bit sampling with a 2-flop synchroniser, start-bit glitch rejection and separate parity/framing error flags. It sits between on-chip logic (parallel data plus start/valid handshake) and the serial pins.

---
 rtl/uart_param_if.sv | 55 +++++
 rtl/uart_param.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_param_if
//  Description : Parallel-side bundle of the parametrised UART. Carries the
//                transmit request/data handshake towards the UART and the
//                receive word, strobe, error flags and busy indications back
//                to on-chip logic.
//  Modports    : master - on-chip logic (drives tx_data/tx_start)
//                slave  - the UART itself
//  Signals     : tx_data      word to transmit
//                tx_start     request to send
//                tx_busy      transmitter active
//                rx_data      last received word
//                rx_valid     one-cycle frame-complete strobe
//                parity_error parity mismatch on last frame
//                frame_error  stop bit sampled low on last frame
//                rx_busy      receiver active
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_error;
    logic                 frame_error;
    logic                 rx_busy;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  rx_data,
        input  rx_valid,
        input  parity_error,
        input  frame_error,
        input  rx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output rx_data,
        output rx_valid,
        output parity_error,
        output frame_error,
        output rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_param
//  Description : Parametrised full-duplex UART. Configurable payload width,
//                parity mode, stop-bit count and baud divider. The receiver
//                uses a 2-flop synchroniser, mid-bit sampling, start-bit
//                glitch rejection and separate parity/framing error flags.
//  Parameters  : CLKS_PER_BIT (>=4), DATA_BITS (5..9),
//                PARITY_MODE (0 none, 1 even, 2 odd), STOP_BITS (1 or 2)
//  Ports       : clk      system clock, rising edge
//                reset    asynchronous active-high reset
//                bus      uart_param_if.slave parallel-side bundle
//                tx       serial output, idle high
//                rx       serial input, asynchronous to clk
//                loopback (only with UART_LOOPBACK_EN) routes the internal
//                         TX bit into the receiver and holds the tx pin high
//  Macro       : UART_LOOPBACK_EN - adds the loopback input port
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  wire          clk,
    input  wire          reset,
    uart_param_if.slave  bus,
    output logic         tx,
    input  wire          rx
`ifdef UART_LOOPBACK_EN
    ,
    input  wire          loopback
`endif
);

    localparam int                  c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]          c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]          c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam bit                  c_HAS_PAR   = (PARITY_MODE != 0);
    localparam logic                c_PAR_INV   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t              r_tx_state, w_tx_state_nxt;
    logic [c_CNT_W-1:0]     r_tx_cnt, w_tx_cnt_nxt;
    logic [3:0]             r_tx_bit_idx, w_tx_bit_idx_nxt;
    logic [DATA_BITS-1:0]   r_tx_shift, w_tx_shift_nxt;
    logic                   r_tx_par, w_tx_par_nxt;
    logic                   r_tx_line, w_tx_line_nxt;
    logic                   w_tx_bit_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state   <= TX_IDLE;
            r_tx_cnt     <= '0;
            r_tx_bit_idx <= '0;
            r_tx_shift   <= '0;
            r_tx_par     <= 1'b0;
            r_tx_line    <= 1'b1;
        end else begin
            r_tx_state   <= w_tx_state_nxt;
            r_tx_cnt     <= w_tx_cnt_nxt;
            r_tx_bit_idx <= w_tx_bit_idx_nxt;
            r_tx_shift   <= w_tx_shift_nxt;
            r_tx_par     <= w_tx_par_nxt;
            r_tx_line    <= w_tx_line_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt   = r_tx_state;
        w_tx_cnt_nxt     = r_tx_cnt;
        w_tx_bit_idx_nxt = r_tx_bit_idx;
        w_tx_shift_nxt   = r_tx_shift;
        w_tx_par_nxt     = r_tx_par;
        w_tx_line_nxt    = 1'b1;
        w_tx_bit_end     = (r_tx_cnt == c_CNT_LAST);

        // The bit-period counter free-runs outside IDLE and wraps at the end
        // of every bit, so it is already zero when the FSM returns to IDLE.
        if (r_tx_state != TX_IDLE) begin
            w_tx_cnt_nxt = w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
        end

        unique case (r_tx_state)
            TX_IDLE: begin
                if (bus.tx_start) begin
                    w_tx_state_nxt   = TX_START;
                    w_tx_shift_nxt   = bus.tx_data;
                    w_tx_par_nxt     = (^bus.tx_data) ^ c_PAR_INV;
                    w_tx_cnt_nxt     = '0;
                    w_tx_bit_idx_nxt = '0;
                end
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    w_tx_shift_nxt = r_tx_shift >> 1;
                    if (r_tx_bit_idx == c_DATA_LAST) begin
                        w_tx_bit_idx_nxt = '0;
                        w_tx_state_nxt   = c_HAS_PAR ? TX_PARITY : TX_STOP;
                    end else begin
                        w_tx_bit_idx_nxt = r_tx_bit_idx + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    if (r_tx_bit_idx == c_STOP_LAST) begin
                        w_tx_bit_idx_nxt = '0;
                        w_tx_state_nxt   = TX_IDLE;
                    end else begin
                        w_tx_bit_idx_nxt = r_tx_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
            end
        endcase

        // The line level is registered alongside the state it belongs to,
        // so tx is glitch-free and changes on the same edge as the state.
        unique case (w_tx_state_nxt)
            TX_START:  w_tx_line_nxt = 1'b0;
            TX_DATA:   w_tx_line_nxt = w_tx_shift_nxt[0];
            TX_PARITY: w_tx_line_nxt = w_tx_par_nxt;
            default:   w_tx_line_nxt = 1'b1;
        endcase
    end

    assign bus.tx_busy = (r_tx_state != TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver input selection and synchroniser
    // ------------------------------------------------------------------
    logic w_rx_pin;

`ifdef UART_LOOPBACK_EN
    assign w_rx_pin = loopback ? r_tx_line : rx;
    assign tx       = r_tx_line | loopback;
`else
    assign w_rx_pin = rx;
    assign tx       = r_tx_line;
`endif

    logic r_rx_meta, r_rx_sync, r_rx_prev;

    // Reset to the idle (high) level so release of reset is never seen as
    // a start-bit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= w_rx_pin;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t              r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0]     r_rx_cnt, w_rx_cnt_nxt;
    logic [3:0]             r_rx_bit_idx, w_rx_bit_idx_nxt;
    logic [DATA_BITS-1:0]   r_rx_shift, w_rx_shift_nxt;
    logic                   r_rx_par_bad, w_rx_par_bad_nxt;
    logic                   r_rx_stop_bad, w_rx_stop_bad_nxt;
    logic [DATA_BITS-1:0]   r_rx_data, w_rx_data_nxt;
    logic                   r_rx_valid, w_rx_valid_nxt;
    logic                   r_parity_error, w_parity_error_nxt;
    logic                   r_frame_error, w_frame_error_nxt;
    logic                   w_rx_bit_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state     <= RX_IDLE;
            r_rx_cnt       <= '0;
            r_rx_bit_idx   <= '0;
            r_rx_shift     <= '0;
            r_rx_par_bad   <= 1'b0;
            r_rx_stop_bad  <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_rx_state     <= w_rx_state_nxt;
            r_rx_cnt       <= w_rx_cnt_nxt;
            r_rx_bit_idx   <= w_rx_bit_idx_nxt;
            r_rx_shift     <= w_rx_shift_nxt;
            r_rx_par_bad   <= w_rx_par_bad_nxt;
            r_rx_stop_bad  <= w_rx_stop_bad_nxt;
            r_rx_data      <= w_rx_data_nxt;
            r_rx_valid     <= w_rx_valid_nxt;
            r_parity_error <= w_parity_error_nxt;
            r_frame_error  <= w_frame_error_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt     = r_rx_state;
        w_rx_cnt_nxt       = r_rx_cnt;
        w_rx_bit_idx_nxt   = r_rx_bit_idx;
        w_rx_shift_nxt     = r_rx_shift;
        w_rx_par_bad_nxt   = r_rx_par_bad;
        w_rx_stop_bad_nxt  = r_rx_stop_bad;
        w_rx_data_nxt      = r_rx_data;
        w_rx_valid_nxt     = 1'b0;
        w_parity_error_nxt = r_parity_error;
        w_frame_error_nxt  = r_frame_error;
        w_rx_bit_end       = (r_rx_cnt == c_CNT_LAST);

        unique case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // Half a bit after the falling edge we are at the start-bit
                // centre; a high level here means the edge was a glitch.
                if (r_rx_cnt == c_CNT_HALF) begin
                    w_rx_cnt_nxt = '0;
                    if (r_rx_sync) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt    = RX_DATA;
                        w_rx_bit_idx_nxt  = '0;
                        w_rx_par_bad_nxt  = 1'b0;
                        w_rx_stop_bad_nxt = 1'b0;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt   = '0;
                    // LSB arrives first, so shift in from the top.
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit_idx == c_DATA_LAST) begin
                        w_rx_bit_idx_nxt = '0;
                        w_rx_state_nxt   = c_HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        w_rx_bit_idx_nxt = r_rx_bit_idx + 1'b1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_PARITY: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt     = '0;
                    w_rx_par_bad_nxt = r_rx_sync ^ (^r_rx_shift) ^ c_PAR_INV;
                    w_rx_state_nxt   = RX_STOP;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt = '0;
                    if (r_rx_bit_idx == c_STOP_LAST) begin
                        // Complete at the last stop-bit centre so a start
                        // bit that follows immediately is still caught.
                        w_rx_bit_idx_nxt   = '0;
                        w_rx_state_nxt     = RX_IDLE;
                        w_rx_data_nxt      = r_rx_shift;
                        w_rx_valid_nxt     = 1'b1;
                        w_parity_error_nxt = r_rx_par_bad;
                        w_frame_error_nxt  = r_rx_stop_bad | ~r_rx_sync;
                    end else begin
                        w_rx_bit_idx_nxt  = r_rx_bit_idx + 1'b1;
                        w_rx_stop_bad_nxt = r_rx_stop_bad | ~r_rx_sync;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.rx_busy     = (r_rx_state != RX_IDLE);

    generate
        if (c_HAS_PAR) begin : g_parity_flag
            assign bus.parity_error = r_parity_error;
        end else begin : g_no_parity_flag
            assign bus.parity_error = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire
